fwrisc_regfile_mp: RTL and testbench

FWRISC_REGFILE_MP -- requirements
Module: fwrisc_regfile_mp

---
 rtl/fwrisc_regfile_pkg.sv | 45 ++++
 rtl/fwrisc_regfile_rdport.sv | 85 ++++++++
 rtl/fwrisc_regfile_mp.sv | 140 ++++++++++++++
 tb/tb_fwrisc_regfile_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_regfile_pkg.sv
// ----------------------------------------------------------------------------
// fwrisc_regfile_pkg
//
// Purpose : shared types and default parameter values for the multi-port
//           register file (fwrisc_regfile_mp) and its read-lane sub-module
//           (fwrisc_regfile_rdport).
//
// Contents:
//   DEFAULT_*          default values for the register file parameters
//   regfile_state_t    top-level controller state (INIT clears the array,
//                      RUN serves user traffic)
//   lane_src_t         per-lane selection of where the registered read data
//                      comes from after the read edge
// ----------------------------------------------------------------------------
package fwrisc_regfile_pkg;

  // Register width in bits.
  localparam int DEFAULT_DATA_W   = 32;
  // Address width; the array holds 2**ADDR_W entries.
  localparam int DEFAULT_ADDR_W   = 6;
  // Number of independent read ports (legal range 1..4).
  localparam int DEFAULT_N_RD     = 2;
  // Entry 0 is hard-wired to zero when non-zero.
  localparam int DEFAULT_ZERO_REG = 1;
  // Same-cycle write data is forwarded to matching reads when non-zero.
  localparam int DEFAULT_BYPASS   = 1;

  // Controller state. INIT walks the clear counter over every entry, RUN is
  // normal operation and is only left through reset.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } regfile_state_t;

  // Which value a read lane presents during the cycle after its read edge.
  //   SRC_ZERO   : forced zero (INIT, reset, or the hard-wired zero entry)
  //   SRC_BYPASS : the write data captured at the read edge
  //   SRC_ARRAY  : the synchronous RAM read (content before the read edge)
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ARRAY  = 2'd2
  } lane_src_t;

endpackage : fwrisc_regfile_pkg

// File: rtl/fwrisc_regfile_rdport.sv
// ----------------------------------------------------------------------------
// fwrisc_regfile_rdport
//
// Purpose : one read lane of the register file. At each rising edge it
//           samples the lane's read address against the write port and
//           the controller state, and registers which value the lane must
//           show for the following cycle: zero, forwarded write data, or
//           the array content read at that same edge. The RAM read itself
//           stays in the top so the storage remains a plain block RAM.
//
// Ports:
//   clock        in  1       rising-edge clock
//   reset        in  1       synchronous active-high reset (lane -> 0)
//   run          in  1       controller is in RUN (user traffic allowed)
//   raddr        in  ADDR_W  lane read address
//   wen          in  1       user write enable
//   waddr        in  ADDR_W  user write address
//   wdata        in  DATA_W  user write data
//   array_rdata  in  DATA_W  registered RAM read of raddr from the same edge
//   rdata        out DATA_W  lane read data (1-cycle latency)
// ----------------------------------------------------------------------------
module fwrisc_regfile_rdport
  import fwrisc_regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = DEFAULT_ZERO_REG,
  parameter int BYPASS   = DEFAULT_BYPASS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_rdata,
  output logic [DATA_W-1:0] rdata
);

  lane_src_t         src_d;
  lane_src_t         src_q;
  logic [DATA_W-1:0] byp_q;

  // Priority of the lane source: INIT forces zero, then the zero entry,
  // then a same-cycle write to the same address, otherwise the array.
  // Writes are only honoured in RUN, so gating with run first also keeps
  // INIT from ever forwarding user data.
  always_comb begin
    src_d = SRC_ARRAY;
    if (!run) begin
      src_d = SRC_ZERO;
    end else if ((ZERO_REG != 0) && (raddr == '0)) begin
      src_d = SRC_ZERO;
    end else if ((BYPASS != 0) && wen && (waddr == raddr)) begin
      src_d = SRC_BYPASS;
    end
  end

  // Source select and forwarded data are the lane's output registers; the
  // forwarded data is only captured when it will actually be used.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q <= SRC_ZERO;
      byp_q <= '0;
    end else begin
      src_q <= src_d;
      if (src_d == SRC_BYPASS) begin
        byp_q <= wdata;
      end
    end
  end

  // Final lane mux, driven only by registers so the output is stable for
  // the whole cycle after the read edge.
  always_comb begin
    rdata = '0;
    case (src_q)
      SRC_BYPASS: rdata = byp_q;
      SRC_ARRAY:  rdata = array_rdata;
      default:    rdata = '0;
    endcase
  end

endmodule : fwrisc_regfile_rdport

// File: rtl/fwrisc_regfile_mp.sv
// ----------------------------------------------------------------------------
// fwrisc_regfile_mp
//
// Purpose : multi-read-port register file with one write port. After reset
//           the controller sweeps every entry to zero (INIT), then raises
//           init_done and accepts user writes (RUN). Each read port has a
//           1-cycle registered latency, optional write-to-read forwarding
//           and an optional hard-wired zero entry.
//
// Ports:
//   clock     in  1             rising-edge clock
//   reset     in  1             synchronous active-high reset
//   rs_raddr  in  N_RD*ADDR_W   packed read addresses, lane i at [i*ADDR_W +: ADDR_W]
//   rs_rdata  out N_RD*DATA_W   packed read data, lane i at [i*DATA_W +: DATA_W]
//   rd_waddr  in  ADDR_W        write address
//   rd_wdata  in  DATA_W        write data
//   rd_wen    in  1             write enable (ignored during INIT)
//   init_done out 1             high once the array clear has completed
//
// N_RD is expected to lie in 1..4.
// ----------------------------------------------------------------------------
module fwrisc_regfile_mp
  import fwrisc_regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int N_RD     = DEFAULT_N_RD,
  parameter int ZERO_REG = DEFAULT_ZERO_REG,
  parameter int BYPASS   = DEFAULT_BYPASS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_RD*ADDR_W-1:0] rs_raddr,
  output logic [N_RD*DATA_W-1:0] rs_rdata,
  input  logic [ADDR_W-1:0]      rd_waddr,
  input  logic [DATA_W-1:0]      rd_wdata,
  input  logic                   rd_wen,
  output logic                   init_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  regfile_state_t    state_q;
  regfile_state_t    state_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;
  logic              run;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Storage has no reset so it maps onto block RAM; INIT clears it instead.
  logic [DATA_W-1:0] mem [DEPTH];

  // The clear counter is on the last entry of the array.
  assign clr_last = (clr_cnt == {ADDR_W{1'b1}});

  // State register and clear counter. The counter stops on the last entry
  // rather than wrapping, so RUN is never re-entered into INIT except by
  // reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == INIT) && !clr_last) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Next-state logic: leave INIT on the edge that clears the last entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (clr_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Output logic: init_done follows RUN directly, and the single RAM write
  // port is shared between the clear sweep (INIT) and user writes (RUN).
  // Nothing is written on a reset edge; the following INIT sweep covers
  // the whole array anyway.
  always_comb begin
    run       = (state_q == RUN);
    init_done = run;
    mem_wen   = 1'b0;
    mem_waddr = clr_cnt;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == INIT) begin
        mem_wen = 1'b1;
      end else if (rd_wen && !((ZERO_REG != 0) && (rd_waddr == '0))) begin
        mem_wen   = 1'b1;
        mem_waddr = rd_waddr;
        mem_wdata = rd_wdata;
      end
    end
  end

  // Single RAM write port.
  always_ff @(posedge clock) begin
    if (mem_wen) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // One synchronous RAM read plus one lane controller per read port. The
  // RAM read samples the array before this edge's write, which gives the
  // read-before-write behaviour when forwarding is disabled.
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [DATA_W-1:0] ram_q;

    always_ff @(posedge clock) begin
      ram_q <= mem[rs_raddr[i*ADDR_W +: ADDR_W]];
    end

    fwrisc_regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rdport (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .raddr       (rs_raddr[i*ADDR_W +: ADDR_W]),
      .wen         (rd_wen),
      .waddr       (rd_waddr),
      .wdata       (rd_wdata),
      .array_rdata (ram_q),
      .rdata       (rs_rdata[i*DATA_W +: DATA_W])
    );
  end

endmodule : fwrisc_regfile_mp

// File: tb/tb_fwrisc_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_fwrisc_regfile_mp
//
// Three register files share one clock:
//   dut_a : defaults (32-bit, 64 entries, 2 read ports, zero reg, bypass)
//   dut_b : same as dut_a but without bypass; driven with dut_a's inputs
//   dut_c : 16-bit, 16 entries, 4 read ports, zero reg, bypass
// A behavioural model (entry array plus a cycles-since-reset count) gives
// the expected lane values and init_done after every edge.
// ----------------------------------------------------------------------------
module tb_fwrisc_regfile_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs shared by dut_a and dut_b.
  logic        reset_l;
  logic [11:0] raddr_l;
  logic [5:0]  waddr_l;
  logic [31:0] wdata_l;
  logic        wen_l;
  logic [63:0] rdata_a;
  logic [63:0] rdata_b;
  logic        done_a;
  logic        done_b;

  // Inputs of dut_c.
  logic        reset_s;
  logic [15:0] raddr_s;
  logic [3:0]  waddr_s;
  logic [15:0] wdata_s;
  logic        wen_s;
  logic [63:0] rdata_c;
  logic        done_c;

  fwrisc_regfile_mp #(.DATA_W(32), .ADDR_W(6), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset_l), .rs_raddr(raddr_l), .rs_rdata(rdata_a),
    .rd_waddr(waddr_l), .rd_wdata(wdata_l), .rd_wen(wen_l), .init_done(done_a));

  fwrisc_regfile_mp #(.DATA_W(32), .ADDR_W(6), .N_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset_l), .rs_raddr(raddr_l), .rs_rdata(rdata_b),
    .rd_waddr(waddr_l), .rd_wdata(wdata_l), .rd_wen(wen_l), .init_done(done_b));

  fwrisc_regfile_mp #(.DATA_W(16), .ADDR_W(4), .N_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clock(clock), .reset(reset_s), .rs_raddr(raddr_s), .rs_rdata(rdata_c),
    .rd_waddr(waddr_s), .rd_wdata(wdata_s), .rd_wen(wen_s), .init_done(done_c));

  // Model state, index 0 = dut_a/dut_b pair, index 1 = dut_c.
  logic [31:0] mdl_mem [2][64];
  int          mdl_cnt [2];

  int          checks   = 0;
  int          failures = 0;

  logic [5:0]  ra [4];
  logic [31:0] lane_a [4];
  logic [31:0] lane_b [4];
  logic [31:0] lane_c [4];
  logic        cur_done;
  int          cyc;

  // One comparison: counts it, and on mismatch counts the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs (read addresses taken from ra[]), predict the
  // result from the model, advance one edge and compare every lane.
  task automatic applyStimulus(input int d, input logic rst, input logic wen,
                               input logic [5:0] wa, input logic [31:0] wd);
    int          depth;
    logic [5:0]  amask;
    logic [31:0] dmask;
    logic [5:0]  a;
    logic [5:0]  wam;
    logic [31:0] exp_fwd [4];
    logic [31:0] exp_old [4];
    logic        exp_done;
    depth = (d == 0) ? 64 : 16;
    amask = (d == 0) ? 6'h3f : 6'h0f;
    dmask = (d == 0) ? 32'hffff_ffff : 32'h0000_ffff;
    wam   = wa & amask;
    if (d == 0) begin
      reset_l = rst; wen_l = wen; waddr_l = wa; wdata_l = wd;
      for (int i = 0; i < 2; i++) raddr_l[i*6 +: 6] = ra[i];
    end else begin
      reset_s = rst; wen_s = wen; waddr_s = wa[3:0]; wdata_s = wd[15:0];
      for (int i = 0; i < 4; i++) raddr_s[i*4 +: 4] = ra[i][3:0];
    end
    // Expected lanes: zero on reset, during the clear sweep and for entry 0;
    // otherwise the stored value, or the write data when forwarding applies.
    for (int i = 0; i < 4; i++) begin
      a = ra[i] & amask;
      exp_old[i] = '0;
      exp_fwd[i] = '0;
      if (!rst && (mdl_cnt[d] >= depth) && (a != 6'd0)) begin
        exp_old[i] = mdl_mem[d][a];
        exp_fwd[i] = (wen && (wam == a)) ? (wd & dmask) : mdl_mem[d][a];
      end
    end
    if (rst) begin
      mdl_cnt[d] = 0;
      for (int j = 0; j < 64; j++) mdl_mem[d][j] = '0;
    end else begin
      if ((mdl_cnt[d] >= depth) && wen && (wam != 6'd0)) mdl_mem[d][wam] = wd & dmask;
      if (mdl_cnt[d] < depth) mdl_cnt[d]++;
    end
    exp_done = !rst && (mdl_cnt[d] >= depth);
    @(posedge clock);
    #1;
    if (d == 0) begin
      for (int i = 0; i < 2; i++) begin
        lane_a[i] = rdata_a[i*32 +: 32];
        lane_b[i] = rdata_b[i*32 +: 32];
        checkOutput($sformatf("a_lane%0d", i), lane_a[i], exp_fwd[i]);
        checkOutput($sformatf("b_lane%0d", i), lane_b[i], exp_old[i]);
      end
      checkOutput("a_init_done", 32'(done_a), 32'(exp_done));
      checkOutput("b_init_done", 32'(done_b), 32'(exp_done));
      cur_done = done_a;
    end else begin
      for (int i = 0; i < 4; i++) begin
        lane_c[i] = 32'(rdata_c[i*16 +: 16]);
        checkOutput($sformatf("c_lane%0d", i), lane_c[i], exp_fwd[i]);
      end
      checkOutput("c_init_done", 32'(done_c), 32'(exp_done));
      cur_done = done_c;
    end
  endtask

  initial begin
    reset_l = 1'b1; raddr_l = '0; waddr_l = '0; wdata_l = '0; wen_l = 1'b0;
    reset_s = 1'b1; raddr_s = '0; waddr_s = '0; wdata_s = '0; wen_s = 1'b0;
    for (int i = 0; i < 4; i++) ra[i] = '0;
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;

    $display("[TB] reset and clear sweep, default configuration");
    applyStimulus(0, 1'b1, 1'b0, 6'd0, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 6'd0, 32'd0);
    cyc = 0;
    cur_done = 1'b0;
    while (!cur_done && cyc < 200) begin
      ra[0] = 6'($urandom_range(0, 63));
      ra[1] = 6'($urandom_range(0, 63));
      applyStimulus(0, 1'b0, 1'b1, 6'($urandom_range(0, 63)), $urandom);
      cyc++;
    end
    checkOutput("init_cycles_a", 32'(cyc), 32'd64);

    $display("[TB] write then read on both ports");
    ra[0] = 6'd0; ra[1] = 6'd0;
    applyStimulus(0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF);
    ra[0] = 6'd5; ra[1] = 6'd5;
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 32'd0);
    checkOutput("rd5_port0", lane_a[0], 32'hDEADBEEF);
    checkOutput("rd5_port1", lane_a[1], 32'hDEADBEEF);

    $display("[TB] same-cycle write/read collision");
    ra[0] = 6'd7; ra[1] = 6'd7;
    applyStimulus(0, 1'b0, 1'b1, 6'd7, 32'h12345678);
    checkOutput("bypass_on", lane_a[0], 32'h12345678);
    checkOutput("bypass_off", lane_b[0], 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 32'd0);
    checkOutput("after_collision_b", lane_b[1], 32'h12345678);

    $display("[TB] zero register");
    ra[0] = 6'd0; ra[1] = 6'd0;
    applyStimulus(0, 1'b0, 1'b1, 6'd0, 32'hFFFFFFFF);
    checkOutput("zero_bypass", lane_a[0], 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 32'd0);
    checkOutput("zero_read", lane_a[1], 32'h0);

    $display("[TB] random traffic, default configuration");
    for (int n = 0; n < 300; n++) begin
      ra[0] = 6'($urandom_range(0, 15));
      ra[1] = ($urandom_range(0, 3) == 0) ? ra[0] : 6'($urandom_range(0, 63));
      applyStimulus(0, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom);
    end

    $display("[TB] reset in RUN and mid-clear");
    ra[0] = 6'd3; ra[1] = 6'd3;
    applyStimulus(0, 1'b0, 1'b1, 6'd3, 32'hCAFEF00D);
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 32'd0);
    checkOutput("rd3_before_reset", lane_a[0], 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 1'b0, 6'd0, 32'd0);
    for (int n = 0; n < 30; n++) applyStimulus(0, 1'b0, 1'b0, 6'd0, 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 6'd0, 32'd0);
    cyc = 0;
    cur_done = 1'b0;
    while (!cur_done && cyc < 200) begin
      applyStimulus(0, 1'b0, 1'b1, 6'd3, 32'h55AA55AA);
      cyc++;
    end
    checkOutput("reinit_cycles_a", 32'(cyc), 32'd64);
    applyStimulus(0, 1'b0, 1'b0, 6'd0, 32'd0);
    checkOutput("rd3_after_reinit", lane_a[0], 32'h0);

    $display("[TB] small configuration, four read ports");
    applyStimulus(1, 1'b1, 1'b0, 6'd0, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 6'd0, 32'd0);
    cyc = 0;
    cur_done = 1'b0;
    while (!cur_done && cyc < 100) begin
      for (int i = 0; i < 4; i++) ra[i] = 6'($urandom_range(0, 15));
      applyStimulus(1, 1'b0, 1'b1, 6'($urandom_range(0, 15)), $urandom);
      cyc++;
    end
    checkOutput("init_cycles_c", 32'(cyc), 32'd16);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) ra[i] = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra[3] = ra[0];
      applyStimulus(1, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fwrisc_regfile_mp
